// File: rtl/hs_pkg.sv
// Shared definitions for the four-phase handshake models: state codes,
// the pointer/count width helper and the ACK pre-capture rule.
package hs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACKED = 2'd2
  } hs_state_e;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ACKED = 2'd2;

  // Smallest r with 2**r >= n; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Pre-capture value of a registered output: rise forces 1, fall forces 0,
  // otherwise the current value is held. Same convention as the C2 PRECAP.
  function automatic logic precap_next(input logic cur, input logic rise,
                                       input logic fall);
    if (rise) return 1'b1;
    if (fall) return 1'b0;
    return cur;
  endfunction

endpackage

// File: rtl/hs_fifo.sv
// Small power-of-two FIFO with registered occupancy; shared by the
// handshake sink and source blocks.
module hs_fifo
  import hs_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [W-1:0]          i_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [clog2(DEPTH):0] o_count,
  output logic [W-1:0]          o_head
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // Full/empty come from the registered count, so a pop never frees a slot
  // for a push on the same edge.
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/hs4_sink.sv
// Responder end of a four-phase return-to-zero bundled-data channel:
// accepts REQ/DATA, buffers DATA in a FIFO and returns ACK.
module hs4_sink
  import hs_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int DELAY = 0
) (
  input  logic                  CK,
  input  logic                  RS,
  input  logic                  ENA,
  input  logic                  REQ,
  input  logic [W-1:0]          DATA,
  output logic                  ACK,
  output logic                  ACK_NEXT,
  output logic                  RD_VALID,
  input  logic                  RD_READY,
  output logic [W-1:0]          RD_DATA,
  output logic [clog2(DEPTH):0] COUNT,
  output logic                  ERR,
  input  logic                  ERR_CLR,
  output logic [1:0]            DBG_STATE,
  output logic [7:0]            DBG_CNT
);

  logic [1:0] r_state;
  logic [7:0] r_cnt;
  logic       r_ack;
  logic       r_err;

  logic       w_full;
  logic       w_empty;
  logic       w_in_wait;
  logic       w_push;
  logic       w_ack_fall;
  logic       w_viol;

  // Read port: a word leaves on any edge where RD_VALID and RD_READY are
  // both high; RD_READY alone does nothing, and ENA has no effect here.
  hs_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (CK),
    .i_rst   (RS),
    .i_push  (w_push),
    .i_pop   (RD_READY),
    .i_data  (DATA),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (COUNT),
    .o_head  (RD_DATA)
  );

  assign w_in_wait  = ENA && (r_state == S_WAIT);
  assign w_push     = w_in_wait && REQ && (r_cnt == 8'd0) && !w_full;
  assign w_viol     = w_in_wait && !REQ;
  assign w_ack_fall = ENA && (r_state == S_ACKED) && !REQ;

  assign ACK_NEXT  = precap_next(r_ack, w_push, w_ack_fall);
  assign ACK       = r_ack;
  assign ERR       = r_err;
  assign RD_VALID  = !w_empty;
  assign DBG_STATE = r_state;
  assign DBG_CNT   = r_cnt;

  always_ff @(posedge CK or posedge RS) begin
    if (RS) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else if (ENA) begin
      case (r_state)
        S_IDLE: begin
          if (REQ) begin
            r_state <= S_WAIT;
            r_cnt   <= 8'(DELAY);
          end
        end
        S_WAIT: begin
          if (!REQ)               r_state <= S_IDLE;
          else if (r_cnt != 8'd0) r_cnt   <= r_cnt - 8'd1;
          else if (!w_full)       r_state <= S_ACKED;
        end
        S_ACKED: begin
          if (!REQ) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ACK_NEXT already folds in ENA, so ACK simply tracks it.
  always_ff @(posedge CK or posedge RS) begin
    if (RS) r_ack <= 1'b0;
    else    r_ack <= ACK_NEXT;
  end

  // A fresh violation beats a simultaneous clear.
  always_ff @(posedge CK or posedge RS) begin
    if (RS)           r_err <= 1'b0;
    else if (w_viol)  r_err <= 1'b1;
    else if (ERR_CLR) r_err <= 1'b0;
  end

endmodule
